// File: rtl/matmul_feeder_pkg.sv
// Shared definitions for the 2x2 matmul operand feeder: FSM states, sizing
// defaults and the operand-buffer select encodings.
package matmul_feeder_pkg;

    localparam int DW_DEFAULT   = 32;
    localparam int KMAX_DEFAULT = 8;

    // Zero-feed cycles after the last operand: two skew stages plus the MAC register
    localparam int DRAIN_CYCLES = 3;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_CAPTURE
    } state_t;

endpackage

// File: rtl/matmul_opbuf.sv
// Operand register file: A (2xK, by row) and B (Kx2, by column), one write
// port and a combinational read of all four stream operands at index rd_k.
module matmul_opbuf
    import matmul_feeder_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int KMAX = KMAX_DEFAULT,
    localparam int KW  = (KMAX > 1) ? $clog2(KMAX) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic          wr_idx,
    input  logic [KW-1:0] wr_k,
    input  logic [DW-1:0] wr_data,
    input  logic [KW-1:0] rd_k,
    output logic [DW-1:0] rd_a0,
    output logic [DW-1:0] rd_a1,
    output logic [DW-1:0] rd_b0,
    output logic [DW-1:0] rd_b1
);

    logic [DW-1:0] a_mem [2][KMAX];
    logic [DW-1:0] b_mem [2][KMAX];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < KMAX; k++) begin
                    a_mem[i][k] <= '0;
                    b_mem[i][k] <= '0;
                end
            end
        end else if (wr_en && (int'(wr_k) < KMAX)) begin
            if (wr_sel == SEL_B) begin
                b_mem[wr_idx][wr_k] <= wr_data;
            end else begin
                a_mem[wr_idx][wr_k] <= wr_data;
            end
        end
    end

    // Out-of-range indices read as zero so a non-power-of-two KMAX stays safe
    always_comb begin
        rd_a0 = '0;
        rd_a1 = '0;
        rd_b0 = '0;
        rd_b1 = '0;
        if (int'(rd_k) < KMAX) begin
            rd_a0 = a_mem[0][rd_k];
            rd_a1 = a_mem[1][rd_k];
            rd_b0 = b_mem[0][rd_k];
            rd_b1 = b_mem[1][rd_k];
        end
    end

endmodule

// File: rtl/matmul_feeder.sv
// Sequences one 2x2xK job into a downstream matrix_mul array: clear the
// accumulators, stream K operand columns, drain the pipeline, latch results.
module matmul_feeder
    import matmul_feeder_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int KMAX  = KMAX_DEFAULT,
    parameter int DRAIN = DRAIN_CYCLES,
    localparam int KW   = (KMAX > 1) ? $clog2(KMAX) : 1,
    localparam int DCW  = (DRAIN > 1) ? $clog2(DRAIN) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic            wr_idx,
    input  logic [KW-1:0]   wr_k,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    input  logic [KW:0]     k_len,
    output logic            busy,
    output logic            done,
    output logic            arr_rst,
    output logic [DW-1:0]   in_a0,
    output logic [DW-1:0]   in_a1,
    output logic [DW-1:0]   in_b0,
    output logic [DW-1:0]   in_b1,
    input  logic [2*DW-1:0] o00,
    input  logic [2*DW-1:0] o01,
    input  logic [2*DW-1:0] o10,
    input  logic [2*DW-1:0] o11,
    output logic [2*DW-1:0] r00,
    output logic [2*DW-1:0] r01,
    output logic [2*DW-1:0] r10,
    output logic [2*DW-1:0] r11,
    output logic            res_valid
);

    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN - 1);

    state_t        state;
    state_t        next_state;
    logic [KW:0]   k_len_q;
    logic [KW:0]   k_cnt;
    logic [DCW-1:0] d_cnt;
    logic          start_ok;
    logic          stream_last;
    logic          drain_last;
    logic          stream_en;
    logic          buf_wr_en;
    logic [DW-1:0] rd_a0;
    logic [DW-1:0] rd_a1;
    logic [DW-1:0] rd_b0;
    logic [DW-1:0] rd_b1;

    assign start_ok    = start && (k_len != '0) && (int'(k_len) <= KMAX);
    assign stream_last = (k_cnt == k_len_q - 1'b1);
    assign drain_last  = (d_cnt == DRAIN_LAST);

    // Buffers are frozen for the whole job so the streamed operands stay coherent
    assign buf_wr_en = wr_en && (state == ST_IDLE);

    matmul_opbuf #(
        .DW   (DW),
        .KMAX (KMAX)
    ) u_opbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr_en),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_k    (wr_k),
        .wr_data (wr_data),
        .rd_k    (k_cnt[KW-1:0]),
        .rd_a0   (rd_a0),
        .rd_a1   (rd_a1),
        .rd_b0   (rd_b0),
        .rd_b1   (rd_b1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        arr_rst    = rst;
        stream_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                arr_rst    = 1'b1;
                next_state = ST_STREAM;
            end
            ST_STREAM: begin
                stream_en = !rst;
                if (stream_last) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_last) next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                done       = !rst;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign in_a0 = stream_en ? rd_a0 : '0;
    assign in_a1 = stream_en ? rd_a1 : '0;
    assign in_b0 = stream_en ? rd_b0 : '0;
    assign in_b1 = stream_en ? rd_b1 : '0;

    // k_cnt doubles as the operand read index during STREAM
    always_ff @(posedge clk) begin
        if (rst) begin
            k_len_q <= '0;
            k_cnt   <= '0;
            d_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        k_len_q <= k_len;
                        k_cnt   <= '0;
                        d_cnt   <= '0;
                    end
                end
                ST_STREAM: k_cnt <= k_cnt + 1'b1;
                ST_DRAIN:  d_cnt <= d_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Results are captured verbatim from the array at the end of the drain window
    always_ff @(posedge clk) begin
        if (rst) begin
            r00       <= '0;
            r01       <= '0;
            r10       <= '0;
            r11       <= '0;
            res_valid <= 1'b0;
        end else if ((state == ST_IDLE) && start_ok) begin
            res_valid <= 1'b0;
        end else if ((state == ST_DRAIN) && drain_last) begin
            r00       <= o00;
            r01       <= o01;
            r10       <= o10;
            r11       <= o11;
            res_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboard bench: matmul_feeder driving a behavioural 2x2 systolic matrix_mul,
// expected results queued at job launch and checked when done pulses.
module tb_matmul_feeder;
    import matmul_feeder_pkg::*;

    localparam int DW   = 32;
    localparam int KMAX = 8;
    localparam int KW   = 3;
    localparam logic [63:0] WRAP = 64'hFFFFFFF000000008;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic            wr_sel;
    logic            wr_idx;
    logic [KW-1:0]   wr_k;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic [KW:0]     k_len;
    logic            busy;
    logic            done;
    logic            arr_rst;
    logic [DW-1:0]   in_a0, in_a1, in_b0, in_b1;
    logic [2*DW-1:0] o00, o01, o10, o11;
    logic [2*DW-1:0] r00, r01, r10, r11;
    logic            res_valid;

    logic [DW-1:0]   a0_p, a1_s, a1_p, b0_p, b1_s, b1_p;

    typedef struct {
        string       name;
        logic [63:0] r00, r01, r10, r11;
        int          kLen;
        int          startCyc;
        int          arrAtStart;
    } exp_t;

    exp_t expQ[$];
    exp_t mon;
    int   cyc = 0;
    int   arrRstCount = 0;
    int   passCount = 0;
    int   checkCount = 0;

    always #5 clk = ~clk;

    matmul_feeder #(
        .DW   (DW),
        .KMAX (KMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_idx    (wr_idx),
        .wr_k      (wr_k),
        .wr_data   (wr_data),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .arr_rst   (arr_rst),
        .in_a0     (in_a0),
        .in_a1     (in_a1),
        .in_b0     (in_b0),
        .in_b1     (in_b1),
        .o00       (o00),
        .o01       (o01),
        .o10       (o10),
        .o11       (o11),
        .r00       (r00),
        .r01       (r01),
        .r10       (r10),
        .r11       (r11),
        .res_valid (res_valid)
    );

    function automatic logic [63:0] mac(logic [63:0] acc, logic [31:0] a, logic [31:0] b);
        return acc + ({32'b0, a} * {32'b0, b});
    endfunction

    // matrix_mul model: row 1 / column 1 are skewed one cycle on entry, operands
    // hop one register between PEs, and each PE accumulates through a register.
    always @(posedge clk) begin
        if (arr_rst) begin
            a0_p <= '0; a1_s <= '0; a1_p <= '0;
            b0_p <= '0; b1_s <= '0; b1_p <= '0;
            o00 <= '0; o01 <= '0; o10 <= '0; o11 <= '0;
        end else begin
            a1_s <= in_a1;
            b1_s <= in_b1;
            a0_p <= in_a0;
            b0_p <= in_b0;
            a1_p <= a1_s;
            b1_p <= b1_s;
            o00  <= mac(o00, in_a0, in_b0);
            o01  <= mac(o01, a0_p, b1_s);
            o10  <= mac(o10, a1_s, b0_p);
            o11  <= mac(o11, a1_p, b1_p);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (arr_rst && !rst) arrRstCount++;
        if (done && !rst) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pulse");
            end else begin
                mon = expQ.pop_front();
                checkOutput({mon.name, ".r00"}, r00, mon.r00);
                checkOutput({mon.name, ".r01"}, r01, mon.r01);
                checkOutput({mon.name, ".r10"}, r10, mon.r10);
                checkOutput({mon.name, ".r11"}, r11, mon.r11);
                checkOutput({mon.name, ".res_valid"}, 64'(res_valid), 64'd1);
                checkOutput({mon.name, ".latency"}, 64'(cyc - mon.startCyc), 64'(mon.kLen + 5));
                checkOutput({mon.name, ".arr_rst_cycles"}, 64'(arrRstCount - mon.arrAtStart), 64'd1);
            end
        end
    end

    task automatic writeElem(input logic sel, input logic idx, input int k, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_idx  = idx;
        wr_k    = KW'(k);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input int kl, input bit expectDone,
                                 input logic [63:0] e00, input logic [63:0] e01,
                                 input logic [63:0] e10, input logic [63:0] e11);
        exp_t e;
        start = 1'b1;
        k_len = 4'(kl);
        if (expectDone) begin
            e.name = name; e.kLen = kl; e.startCyc = cyc; e.arrAtStart = arrRstCount;
            e.r00 = e00; e.r01 = e01; e.r10 = e10; e.r11 = e11;
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0 || busy) begin
            checkCount++;
            $display("[TB] FAIL %s.timeout: got no done within %0d cycles, expected done", name, budget);
            expQ.delete();
        end
    endtask

    initial begin
        int arrBefore;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_idx = 1'b0; wr_k = '0; wr_data = '0;
        start = 1'b0; k_len = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.arr_rst", 64'(arr_rst), 64'd1);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle.arr_rst", 64'(arr_rst), 64'd0);
        checkOutput("idle.res_valid", 64'(res_valid), 64'd0);
        checkOutput("idle.r00", r00, 64'd0);
        checkOutput("idle.in_a0", 64'(in_a0), 64'd0);

        // Identity: A=[[1,2],[3,4]], B=I
        writeElem(SEL_A, 0, 0, 1); writeElem(SEL_A, 0, 1, 2);
        writeElem(SEL_A, 1, 0, 3); writeElem(SEL_A, 1, 1, 4);
        writeElem(SEL_B, 0, 0, 1); writeElem(SEL_B, 1, 1, 1);
        applyStimulus("identity", 2, 1'b1, 1, 2, 3, 4);
        checkOutput("identity.busy", 64'(busy), 64'd1);
        waitIdle("identity", 50);

        // Back-to-back k=1; stale k=1 entries must not contribute
        writeElem(SEL_A, 0, 0, 5); writeElem(SEL_A, 1, 0, 6);
        writeElem(SEL_B, 0, 0, 7); writeElem(SEL_B, 1, 0, 8);
        applyStimulus("b2b", 1, 1'b1, 35, 40, 42, 48);
        waitIdle("b2b", 50);
        repeat (3) @(negedge clk);
        checkOutput("hold.res_valid", 64'(res_valid), 64'd1);
        checkOutput("hold.r11", r11, 64'd48);

        // Illegal k_len values
        arrBefore = arrRstCount;
        applyStimulus("illegal0", 0, 1'b0, 0, 0, 0, 0);
        checkOutput("illegal0.busy", 64'(busy), 64'd0);
        applyStimulus("illegal9", 9, 1'b0, 0, 0, 0, 0);
        checkOutput("illegal9.busy", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);
        checkOutput("illegal.arr_rst_cycles", 64'(arrRstCount - arrBefore), 64'd0);
        checkOutput("illegal.res_valid", 64'(res_valid), 64'd1);
        checkOutput("illegal.r00", r00, 64'd35);

        // Start and write while busy are both ignored
        applyStimulus("busy_job", 2, 1'b1, 35, 42, 42, 52);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = SEL_A; wr_idx = 1'b0; wr_k = '0; wr_data = 100;
        start = 1'b1; k_len = 4'd1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        waitIdle("busy_job", 50);
        applyStimulus("after_busy", 1, 1'b1, 35, 40, 42, 48);
        waitIdle("after_busy", 50);

        // Write and start in the same IDLE cycle
        wr_en = 1'b1; wr_sel = SEL_A; wr_idx = 1'b0; wr_k = '0; wr_data = 9;
        applyStimulus("same_cycle", 1, 1'b1, 63, 72, 42, 48);
        wr_en = 1'b0;
        waitIdle("same_cycle", 50);

        // Width wrap at full K
        for (int k = 0; k < KMAX; k++) begin
            for (int i = 0; i < 2; i++) begin
                writeElem(SEL_A, 1'(i), k, 32'hFFFFFFFF);
                writeElem(SEL_B, 1'(i), k, 32'hFFFFFFFF);
            end
        end
        applyStimulus("wrap", 8, 1'b1, WRAP, WRAP, WRAP, WRAP);
        waitIdle("wrap", 50);

        // Reset in STREAM cycle 1 of a k=4 job
        applyStimulus("abort", 4, 1'b0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("abort.in_b1", 64'(in_b1), 64'hFFFFFFFF);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort.arr_rst", 64'(arr_rst), 64'd1);
        checkOutput("abort.busy", 64'(busy), 64'd0);
        checkOutput("abort.in_all", 64'(in_a0 | in_a1 | in_b0 | in_b1), 64'd0);
        checkOutput("abort.res_valid", 64'(res_valid), 64'd0);
        checkOutput("abort.r00", r00, 64'd0);
        checkOutput("abort.r11", r11, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus("zeroed", 3, 1'b1, 0, 0, 0, 0);
        waitIdle("zeroed", 50);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
